// File: rtl/change_pkg.sv
// Shared types and constants for the change dispenser: FSM states,
// coin denominations and refill tube-select encodings.
package change_pkg;

    localparam int CHANGE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SELECT,
        ST_EJECT,
        ST_GAP
    } state_t;

    localparam logic [CHANGE_W-1:0] DENOM_1 = 4'd1;
    localparam logic [CHANGE_W-1:0] DENOM_2 = 4'd2;
    localparam logic [CHANGE_W-1:0] DENOM_3 = 4'd3;

    typedef enum logic [1:0] {
        SEL_NONE  = 2'b00,
        SEL_TUBE1 = 2'b01,
        SEL_TUBE2 = 2'b10,
        SEL_TUBE3 = 2'b11
    } refill_sel_t;

    // Coin value of a one-hot tube select (bit0 = tube1 ... bit2 = tube3).
    function automatic logic [CHANGE_W-1:0] denom_of(input logic [2:0] onehot);
        logic [CHANGE_W-1:0] value;
        value = '0;
        if (onehot[2])      value = DENOM_3;
        else if (onehot[1]) value = DENOM_2;
        else if (onehot[0]) value = DENOM_1;
        return value;
    endfunction

endpackage

// File: rtl/change_dispenser_coin_tube.sv
// Inventory counter for one coin tube: saturating refill, guarded decrement,
// registered empty flag.
module coin_tube #(
    parameter int INIT_COUNT = 8,
    parameter int TUBE_MAX   = 15,
    parameter int CNT_W      = $clog2(TUBE_MAX + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [CNT_W-1:0] count_next;

    // A refill and a payout hitting the same tube in one cycle cancel out.
    always_comb begin
        count_next = count;
        if (inc && !dec) begin
            if (count < CNT_W'(TUBE_MAX))
                count_next = count + CNT_W'(1);
        end else if (dec && !inc) begin
            if (count != '0)
                count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= CNT_W'(INIT_COUNT);
            empty <= (INIT_COUNT == 0);
        end else begin
            count <= count_next;
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Pays a change amount back as 3/2/1 coins, one timed solenoid pulse per coin,
// greedily choosing the largest coin available in the tubes.
module change_dispenser
    import change_pkg::*;
#(
    parameter int EJECT_CYCLES = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int INIT_COUNT   = 8,
    parameter int TUBE_MAX     = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                dispense,
    input  logic [CHANGE_W-1:0] change,
    input  logic                refill,
    input  logic [1:0]          refill_sel,
    output logic                eject_1,
    output logic                eject_2,
    output logic                eject_3,
    output logic                busy,
    output logic                pay_done,
    output logic                short_pay,
    output logic [2:0]          tube_empty,
    output logic                exact_change_only
);

    localparam int TUBE_W  = $clog2(TUBE_MAX + 1);
    localparam int TMR_MAX = (EJECT_CYCLES > GAP_CYCLES) ? EJECT_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    state_t              state, state_next;
    logic [CHANGE_W-1:0] remaining, remaining_next;
    logic [TMR_W-1:0]    tmr, tmr_next;
    logic [2:0]          eject, eject_next;
    logic                busy_next, pay_done_next, short_next;
    logic [2:0]          inc, dec, pick;
    logic [TUBE_W-1:0]   count [3];
    logic [2:0]          empty;

    assign inc[0] = refill && (refill_sel == SEL_TUBE1);
    assign inc[1] = refill && (refill_sel == SEL_TUBE2);
    assign inc[2] = refill && (refill_sel == SEL_TUBE3);

    coin_tube #(.INIT_COUNT(INIT_COUNT), .TUBE_MAX(TUBE_MAX), .CNT_W(TUBE_W)) u_tube1 (
        .clk(clk), .reset(reset), .inc(inc[0]), .dec(dec[0]), .count(count[0]), .empty(empty[0])
    );
    coin_tube #(.INIT_COUNT(INIT_COUNT), .TUBE_MAX(TUBE_MAX), .CNT_W(TUBE_W)) u_tube2 (
        .clk(clk), .reset(reset), .inc(inc[1]), .dec(dec[1]), .count(count[1]), .empty(empty[1])
    );
    coin_tube #(.INIT_COUNT(INIT_COUNT), .TUBE_MAX(TUBE_MAX), .CNT_W(TUBE_W)) u_tube3 (
        .clk(clk), .reset(reset), .inc(inc[2]), .dec(dec[2]), .count(count[2]), .empty(empty[2])
    );

    // Strict greedy choice, no lookahead: largest coin that fits and is stocked.
    always_comb begin
        pick = '0;
        if (remaining >= DENOM_3 && count[2] != '0)      pick = 3'b100;
        else if (remaining >= DENOM_2 && count[1] != '0) pick = 3'b010;
        else if (remaining >= DENOM_1 && count[0] != '0) pick = 3'b001;
    end

    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        tmr_next       = tmr;
        eject_next     = '0;
        pay_done_next  = 1'b0;
        short_next     = 1'b0;
        dec            = '0;
        case (state)
            ST_IDLE: begin
                if (dispense && change != '0) begin
                    remaining_next = change;
                    state_next     = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (remaining == '0) begin
                    pay_done_next = 1'b1;
                    state_next    = ST_IDLE;
                end else if (pick == '0) begin
                    pay_done_next  = 1'b1;
                    short_next     = 1'b1;
                    remaining_next = '0;
                    state_next     = ST_IDLE;
                end else begin
                    dec            = pick;
                    eject_next     = pick;
                    remaining_next = remaining - denom_of(pick);
                    tmr_next       = TMR_W'(EJECT_CYCLES - 1);
                    state_next     = ST_EJECT;
                end
            end
            ST_EJECT: begin
                if (tmr == '0) begin
                    tmr_next   = TMR_W'(GAP_CYCLES - 1);
                    state_next = ST_GAP;
                end else begin
                    tmr_next   = tmr - TMR_W'(1);
                    eject_next = eject;
                end
            end
            ST_GAP: begin
                if (tmr == '0)
                    state_next = ST_SELECT;
                else
                    tmr_next = tmr - TMR_W'(1);
            end
            default: state_next = ST_IDLE;
        endcase
        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            remaining <= '0;
            tmr       <= '0;
            eject     <= '0;
            busy      <= 1'b0;
            pay_done  <= 1'b0;
            short_pay <= 1'b0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
            tmr       <= tmr_next;
            eject     <= eject_next;
            busy      <= busy_next;
            pay_done  <= pay_done_next;
            short_pay <= short_next;
        end
    end

    assign eject_1           = eject[0];
    assign eject_2           = eject[1];
    assign eject_3           = eject[2];
    assign tube_empty        = empty;
    assign exact_change_only = empty[0];

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized and directed bench for change_dispenser against a timestamp-based
// payout model (coin schedule + inventory array).
module tb_change_dispenser;

    localparam int E    = 4;
    localparam int G    = 2;
    localparam int INIT = 8;
    localparam int TMAX = 15;

    logic       clk = 1'b0;
    logic       reset, dispense, refill;
    logic [3:0] change;
    logic [1:0] refill_sel;
    logic       eject_1, eject_2, eject_3, busy, pay_done, short_pay, exact_change_only;
    logic [2:0] tube_empty;

    always #5 clk = ~clk;

    change_dispenser #(
        .EJECT_CYCLES(E),
        .GAP_CYCLES(G),
        .INIT_COUNT(INIT),
        .TUBE_MAX(TMAX)
    ) u_dut (
        .clk(clk), .reset(reset), .dispense(dispense), .change(change),
        .refill(refill), .refill_sel(refill_sel),
        .eject_1(eject_1), .eject_2(eject_2), .eject_3(eject_3),
        .busy(busy), .pay_done(pay_done), .short_pay(short_pay),
        .tube_empty(tube_empty), .exact_change_only(exact_change_only)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: inventory per denomination, and for the current payout
    // the edge of its next coin decision and the pulse window of the current coin.
    int       m_inv [3];
    bit       m_active = 1'b0;
    bit       m_valid  = 1'b0;
    int       m_rem, m_sel_edge, m_ej_start, m_ej_d;
    int       cyc = 0;
    bit [2:0] x_eject, x_empty;
    bit       x_busy, x_pay, x_short;

    always @(posedge clk) begin
        int dec_i, inc_i, d;
        cyc++;
        x_pay   = 1'b0;
        x_short = 1'b0;
        if (!reset) begin
            for (int i = 0; i < 3; i++) m_inv[i] = INIT;
            m_active = 1'b0;
            m_ej_d   = 0;
            x_eject  = '0;
            x_busy   = 1'b0;
        end else begin
            dec_i = -1;
            if (!m_active) begin
                if (dispense && change != 0) begin
                    m_active   = 1'b1;
                    m_rem      = int'(change);
                    m_sel_edge = cyc + 1;
                    m_ej_d     = 0;
                end
            end else if (cyc == m_sel_edge) begin
                d = 0;
                for (int k = 3; k >= 1; k--)
                    if (d == 0 && k <= m_rem && m_inv[k-1] > 0) d = k;
                if (m_rem == 0 || d == 0) begin
                    x_pay    = 1'b1;
                    x_short  = (m_rem != 0);
                    m_active = 1'b0;
                    m_ej_d   = 0;
                end else begin
                    dec_i      = d - 1;
                    m_rem      = m_rem - d;
                    m_ej_d     = d;
                    m_ej_start = cyc;
                    m_sel_edge = cyc + 1 + E + G;
                end
            end
            inc_i = (refill && refill_sel != 2'b00) ? int'(refill_sel) - 1 : -1;
            if (inc_i != dec_i) begin
                if (inc_i >= 0 && m_inv[inc_i] < TMAX) m_inv[inc_i]++;
                if (dec_i >= 0) m_inv[dec_i]--;
            end
            x_busy  = m_active;
            x_eject = '0;
            if (m_active && m_ej_d != 0 && cyc >= m_ej_start && cyc < m_ej_start + E)
                x_eject[m_ej_d-1] = 1'b1;
        end
        for (int i = 0; i < 3; i++) x_empty[i] = (m_inv[i] == 0);
        m_valid = 1'b1;
    end

    int n_paydone  = 0;
    int n_e2_pulse = 0;
    bit prev_e2    = 1'b0;

    always @(negedge clk) begin
        if (m_valid) begin
            check("ejects", int'({eject_3, eject_2, eject_1}), int'(x_eject));
            check("ejects_onehot0", int'($countones({eject_3, eject_2, eject_1}) <= 1), 1);
            check("busy", int'(busy), int'(x_busy));
            check("pay_done", int'(pay_done), int'(x_pay));
            check("short_pay", int'(short_pay), int'(x_short));
            check("tube_empty", int'(tube_empty), int'(x_empty));
            check("exact_change_only", int'(exact_change_only), int'(x_empty[0]));
        end
        if (pay_done) n_paydone++;
        if (eject_2 && !prev_e2) n_e2_pulse++;
        prev_e2 = eject_2;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input bit noisy);
        int n = 0;
        while (m_active && n < 300) begin
            if (noisy) begin
                refill     = ($urandom_range(0, 3) == 0);
                refill_sel = 2'($urandom_range(0, 3));
                dispense   = ($urandom_range(0, 5) == 0);
                change     = 4'($urandom_range(0, 15));
            end
            tick();
            n++;
        end
        refill   = 1'b0;
        dispense = 1'b0;
        tick();
        check("busy_after_payout", int'(busy), 0);
        tick();
    endtask

    task automatic do_pay(input int amt, input bit noisy);
        dispense = 1'b1;
        change   = 4'(amt);
        tick();
        dispense = 1'b0;
        wait_idle(noisy);
    endtask

    int pd0, e20;

    initial begin
        reset = 1'b0; dispense = 1'b0; change = '0; refill = 1'b0; refill_sel = '0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (4) tick();

        // Zero amount is ignored.
        pd0 = n_paydone;
        do_pay(0, 1'b0);
        check("zero_change_no_paydone", n_paydone - pd0, 0);

        do_pay(1, 1'b0);
        check("tube1_after_one", int'(u_dut.u_tube1.count), 7);
        do_pay(5, 1'b0);
        check("tube3_after_five", int'(u_dut.u_tube3.count), 7);
        check("tube2_after_five", int'(u_dut.u_tube2.count), 7);

        for (int i = 0; i < 20 && m_inv[0] > 0; i++) do_pay(1, 1'b0);
        check("tube1_drained", int'(u_dut.u_tube1.count), 0);
        check("exact_only_drained", int'(exact_change_only), 1);
        do_pay(4, 1'b0);
        check("tube3_after_short", int'(u_dut.u_tube3.count), 6);
        check("exact_only_after_short", int'(exact_change_only), 1);

        // Refill coinciding with decrement; dispense during EJECT ignored.
        reset = 1'b0; tick(); reset = 1'b1; tick();
        pd0 = n_paydone; e20 = n_e2_pulse;
        dispense = 1'b1; change = 4'd2; tick();
        dispense = 1'b0; refill = 1'b1; refill_sel = 2'b10; tick();
        refill = 1'b0; tick();
        dispense = 1'b1; change = 4'd3; tick();
        dispense = 1'b0;
        wait_idle(1'b0);
        check("one_paydone", n_paydone - pd0, 1);
        check("one_eject2_pulse", n_e2_pulse - e20, 1);
        check("tube2_unchanged", int'(u_dut.u_tube2.count), 8);
        repeat (8) begin refill = 1'b1; refill_sel = 2'b10; tick(); end
        refill = 1'b0; tick();
        check("tube2_saturated", int'(u_dut.u_tube2.count), 15);

        // Reset during the second cycle of an eject_3 pulse.
        pd0 = n_paydone;
        dispense = 1'b1; change = 4'd3; tick();
        dispense = 1'b0; tick();
        tick();
        check("eject3_before_reset", int'(eject_3), 1);
        reset = 1'b0; tick();
        reset = 1'b1;
        check("eject3_after_reset", int'(eject_3), 0);
        check("busy_after_reset", int'(busy), 0);
        repeat (12) tick();
        check("no_paydone_after_reset", n_paydone - pd0, 0);
        check("tube1_reinit", int'(u_dut.u_tube1.count), 8);
        check("tube2_reinit", int'(u_dut.u_tube2.count), 8);
        check("tube3_reinit", int'(u_dut.u_tube3.count), 8);

        for (int i = 0; i < 40; i++) do_pay(int'($urandom_range(0, 15)), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
